// File: rtl/atcaxi2tluh500_pipe_slice_pkg.sv
// Shared sizing helpers for the valid/ready pipeline slice.
// Define ATCAXI2TLUH500_PIPE_SLICE_SKID_EN for 2-entry skid stages.
package atcaxi2tluh500_pipe_slice_pkg;

`ifdef ATCAXI2TLUH500_PIPE_SLICE_SKID_EN
  localparam int unsigned STAGE_CAP = 2;
`else
  localparam int unsigned STAGE_CAP = 1;
`endif

  function automatic int unsigned cap_f(input int unsigned depth);
    return STAGE_CAP * depth;
  endfunction

  function automatic int unsigned cw_f(input int unsigned depth);
    return $clog2(cap_f(depth) + 1);
  endfunction

endpackage

// File: rtl/atcaxi2tluh500_pipe_slice_stage.sv
// One register stage of the slice: plain register or 2-entry skid.
// Skid variant selected by ATCAXI2TLUH500_PIPE_SLICE_SKID_EN.
module atcaxi2tluh500_pipe_slice_stage #(
  parameter int unsigned W = 8,
  parameter bit          R = 1'b0
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         vq;
  logic [W-1:0] dq;

  assign out_valid = vq;
  assign out_data  = dq;

`ifdef ATCAXI2TLUH500_PIPE_SLICE_SKID_EN
  logic         sv;
  logic [W-1:0] sd;
  logic         in_fire;
  logic         drain;
  logic         ld_main;
  logic         ld_skid;
  logic [W-1:0] main_nxt;

  // ready is the registered skid-empty flag
  assign in_ready = !sv;
  assign in_fire  = in_valid && !sv && !flush;
  assign drain    = !vq || out_ready;
  assign ld_main  = !flush && drain && (sv || in_fire);
  assign ld_skid  = !flush && !drain && in_fire;
  assign main_nxt = sv ? sd : in_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vq <= 1'b0;
      sv <= 1'b0;
    end else if (flush) begin
      vq <= 1'b0;
      sv <= 1'b0;
    end else if (drain) begin
      vq <= sv || in_fire;
      sv <= 1'b0;
    end else if (in_fire) begin
      sv <= 1'b1;
    end
  end

  if (R) begin : g_rst
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        dq <= '0;
        sd <= '0;
      end else begin
        if (ld_main) dq <= main_nxt;
        if (ld_skid) sd <= in_data;
      end
    end
  end else begin : g_nrst
    always_ff @(posedge clk) begin
      if (ld_main) dq <= main_nxt;
      if (ld_skid) sd <= in_data;
    end
  end
`else
  logic load;

  assign in_ready = !vq || out_ready;
  assign load     = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vq <= 1'b0;
    end else if (flush) begin
      vq <= 1'b0;
    end else if (load) begin
      vq <= 1'b1;
    end else if (out_ready) begin
      vq <= 1'b0;
    end
  end

  if (R) begin : g_rst
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        dq <= '0;
      end else if (load) begin
        dq <= in_data;
      end
    end
  end else begin : g_nrst
    always_ff @(posedge clk) begin
      if (load) dq <= in_data;
    end
  end
`endif

endmodule

// File: rtl/atcaxi2tluh500_pipe_slice.sv
// DEPTH-stage valid/ready register slice with flush and occupancy count.
// Define ATCAXI2TLUH500_PIPE_SLICE_SKID_EN for registered-ready skid stages.
module atcaxi2tluh500_pipe_slice
  import atcaxi2tluh500_pipe_slice_pkg::*;
#(
  parameter  int unsigned W     = 8,
  parameter  int unsigned DEPTH = 1,
  parameter  bit          R     = 1'b0,
  localparam int unsigned CW    = cw_f(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [W-1:0]  s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [W-1:0]  m_data,
  output logic [CW-1:0] count
);

  logic [DEPTH:0]        v;
  logic [DEPTH:0]        r;
  logic [DEPTH:0][W-1:0] d;
  logic                  s_fire;
  logic                  m_fire;

  assign v[0]     = s_valid && !flush;
  assign d[0]     = s_data;
  assign r[DEPTH] = m_ready;
  assign s_ready  = r[0] && resetn && !flush;
  assign m_valid  = v[DEPTH];
  assign m_data   = d[DEPTH];
  assign s_fire   = s_valid && s_ready;
  assign m_fire   = m_valid && m_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    atcaxi2tluh500_pipe_slice_stage #(
      .W (W),
      .R (R)
    ) u_stage (
      .clk       (clk),
      .resetn    (resetn),
      .flush     (flush),
      .in_valid  (v[i]),
      .in_ready  (r[i]),
      .in_data   (d[i]),
      .out_valid (v[i+1]),
      .out_ready (r[i+1]),
      .out_data  (d[i+1])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (s_fire && !m_fire) begin
      count <= count + CW'(1);
    end else if (!s_fire && m_fire) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_atcaxi2tluh500_pipe_slice.sv
// Scoreboard bench for the pipeline slice (W=32, DEPTH=3, R=1).
// Honours ATCAXI2TLUH500_PIPE_SLICE_SKID_EN for capacity expectations.
module tb_atcaxi2tluh500_pipe_slice;

  localparam int W     = 32;
  localparam int DEPTH = 3;
`ifdef ATCAXI2TLUH500_PIPE_SLICE_SKID_EN
  localparam bit SKID  = 1'b1;
  localparam int CAP   = 2 * DEPTH;
`else
  localparam bit SKID  = 1'b0;
  localparam int CAP   = DEPTH;
`endif
  localparam int CW    = $clog2(CAP + 1);

  logic          clk;
  logic          resetn;
  logic          flush;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_data;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic [CW-1:0] count;

  atcaxi2tluh500_pipe_slice #(
    .W     (W),
    .DEPTH (DEPTH),
    .R     (1'b1)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .flush   (flush),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      if (nerr <= 20)
        $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [W-1:0] sb[$];
  int  mcount = 0;
  int  edge_cnt = 0;
  bit  last_s_fire = 0;
  bit  pv = 0, pr = 0, pfl = 0;
  logic [W-1:0] pd = '0;
  bit  lat_arm = 0;
  int  first_acc = -1, last_acc = -1;
  int  first_mv = -1;
  int  first_mf = -1, last_mf = -1, mf_n = 0;

  always @(posedge clk) edge_cnt++;

  // model: transfers sampled mid-cycle take effect at the next edge
  always @(negedge clk) begin
    bit sf, mf;
    if (!resetn) begin
      sb.delete();
      mcount = 0;
      pv = 0;
      last_s_fire = 0;
    end else begin
      chk("count", 64'(count), 64'(mcount));
      if (pv && !pr && !pfl)
        chk("m_hold", {31'd0, m_valid, m_data}, {31'd0, 1'b1, pd});
      sf = s_valid && s_ready;
      mf = m_valid && m_ready;
      last_s_fire = sf;
      if (mf) begin
        if (sb.size() == 0) chk("m_extra", 64'(sb.size()), 64'd1);
        else chk("m_data", 64'(m_data), 64'(sb.pop_front()));
      end
      if (flush) begin
        sb.delete();
        mcount = 0;
      end else begin
        if (sf) sb.push_back(s_data);
        mcount = mcount + int'(sf) - int'(mf);
      end
      if (lat_arm) begin
        if (sf) begin
          if (first_acc < 0) first_acc = edge_cnt + 1;
          last_acc = edge_cnt + 1;
        end
        if (m_valid && first_mv < 0) first_mv = edge_cnt;
        if (mf) begin
          if (first_mf < 0) first_mf = edge_cnt + 1;
          last_mf = edge_cnt + 1;
          mf_n++;
        end
      end
      pv = m_valid;
      pr = m_ready;
      pd = m_data;
      pfl = flush;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] dv);
    int cyc = 0;
    s_valid = 1'b1;
    s_data  = dv;
    do begin
      step();
      cyc++;
    end while (!last_s_fire && cyc < 100);
    if (!last_s_fire) chk("send_to", 64'(cyc), 64'd0);
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    while ((sb.size() != 0 || m_valid) && cyc < 500) begin
      step();
      cyc++;
    end
    chk("drain_sb", 64'(sb.size()), 64'd0);
    chk("drain_cnt", 64'(count), 64'd0);
  endtask

  initial begin
    int i, cyc, acc, n;
    resetn  = 1'b0;
    flush   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    #2;
    chk("rst_mvalid", 64'(m_valid), 64'd0);
    chk("rst_count",  64'(count),   64'd0);
    chk("rst_sready", 64'(s_ready), 64'd0);
    chk("rst_mdata",  64'(m_data),  64'd0);
    @(negedge clk);
    #2 resetn = 1'b1;
    #1 chk("rel_sready", 64'(s_ready), 64'd1);
    step();

    // back-to-back stream with free output
    lat_arm = 1;
    m_ready = 1'b1;
    i = 1;
    cyc = 0;
    while (i <= 16 && cyc < 100) begin
      s_valid = 1'b1;
      s_data  = W'(i);
      step();
      cyc++;
      if (last_s_fire) i++;
    end
    s_valid = 1'b0;
    repeat (10) step();
    lat_arm = 0;
    chk("latency", 64'(first_mv - first_acc), 64'(DEPTH - 1));
    chk("acc_span", 64'(last_acc - first_acc), 64'd15);
    chk("thru_span", 64'(last_mf - first_mf), 64'd15);
    chk("thru_n", 64'(mf_n), 64'd16);

    // back-pressure fill
    m_ready = 1'b0;
    acc = 0;
    s_data = 32'h100;
    for (int k = 0; k < CAP + 3; k++) begin
      s_valid = 1'b1;
      step();
      if (last_s_fire) begin
        acc++;
        s_data = s_data + 1;
      end
    end
    chk("fill_acc", 64'(acc), 64'(CAP));
    chk("fill_cnt", 64'(count), 64'(CAP));
    chk("fill_srdy", 64'(s_ready), 64'd0);
    m_ready = 1'b1;
    #1 chk("srdy_comb", 64'(s_ready), SKID ? 64'd0 : 64'd1);
    m_ready = 1'b0;
    s_valid = 1'b0;
    drain();

    // flush with traffic on both sides
    m_ready = 1'b0;
    send(32'hA1);
    send(32'hA2);
    chk("pre_fl_cnt", 64'(count), 64'd2);
    s_valid = 1'b1;
    s_data  = 32'hA3;
    m_ready = 1'b1;
    flush   = 1'b1;
    #1 chk("fl_sready", 64'(s_ready), 64'd0);
    step();
    chk("fl_noacc", 64'(last_s_fire), 64'd0);
    flush   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    chk("fl_cnt", 64'(count), 64'd0);
    chk("fl_mvalid", 64'(m_valid), 64'd0);
    step();

    // asynchronous reset mid-stream
    send(32'hB1);
    send(32'hB2);
    send(32'hB3);
    chk("pre_rst_cnt", 64'(count), 64'd3);
    s_valid = 1'b1;
    s_data  = 32'hB4;
    m_ready = 1'b1;
    #2 resetn = 1'b0;
    #1;
    chk("arst_mvalid", 64'(m_valid), 64'd0);
    chk("arst_count",  64'(count),   64'd0);
    chk("arst_mdata",  64'(m_data),  64'd0);
    chk("arst_sready", 64'(s_ready), 64'd0);
    s_valid = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    #2 resetn = 1'b1;
    #1 chk("arel_sready", 64'(s_ready), 64'd1);
    step();

    // random valid/ready with held offers
    n = 0;
    cyc = 0;
    s_valid = 1'b0;
    while (n < 3000 && cyc < 30000) begin
      if (last_s_fire) n++;
      if (!s_valid || last_s_fire) begin
        s_valid = ($urandom_range(0, 3) != 0);
        s_data  = $urandom;
      end
      m_ready = (cyc % 400 < 200) ? ($urandom_range(0, 3) != 0)
                                  : ($urandom_range(0, 3) == 0);
      step();
      cyc++;
    end
    chk("rand_beats", 64'(n >= 3000), 64'd1);
    drain();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
